// File: rtl/riscv_pkg.sv
// Shared front-end constants and the fetch FSM state encoding.
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a bubble load wins over an instruction load; otherwise it holds.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);
  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);

  logic [DATA_WIDTH-1:0] instr_d, instr_q, pc_d, pc_q, pc_plus4_d, pc_plus4_q;
  logic                  valid_d, valid_q;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    // A bubble keeps the PC fields so decode still sees the last real PC.
    if (bubble_i) begin
      instr_d = NOP_W;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + DATA_WIDTH'(4);
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= NOP_W;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/fetch.sv
// Instruction fetch: one-outstanding request FSM, PC, one-entry response buffer, IF/ID register.
module fetch
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] instrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  fetch_state_t          state_d, state_q;
  logic [DATA_WIDTH-1:0] pcf_d, pcf_q, pc_req_d, pc_req_q, buf_d, buf_q;
  logic [DATA_WIDTH-1:0] redirect_pc, deliver_instr;
  logic                  req_fire, deliver, if_bubble;

  assign imem_req_valid = rst_n && (state_q == FS_REQ) && !StallF;
  assign imem_req_addr  = pcf_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect_pc    = {PCTargetE[DATA_WIDTH-1:2], 2'b00};

  // Delivery still happens under FlushD (PC advances); only the IF/ID load is squashed.
  assign deliver = !PCSrcE && !StallD &&
                   (((state_q == FS_WAIT) && imem_rsp_valid) || (state_q == FS_HOLD));
  assign deliver_instr = (state_q == FS_HOLD) ? buf_q : imem_rsp_data;
  assign if_bubble     = PCSrcE || FlushD || (!StallD && !deliver);

  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    pc_req_d = pc_req_q;
    buf_d    = buf_q;
    case (state_q)
      FS_REQ: begin
        if (req_fire) pc_req_d = pcf_q;
        if (PCSrcE)        state_d = req_fire ? FS_DROP : FS_REQ;
        else if (req_fire) state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (PCSrcE) begin
          state_d = imem_rsp_valid ? FS_REQ : FS_DROP;
        end else if (imem_rsp_valid) begin
          if (StallD) begin
            buf_d   = imem_rsp_data;
            state_d = FS_HOLD;
          end else begin
            pcf_d   = pc_req_q + FOUR;
            state_d = FS_REQ;
          end
        end
      end
      FS_HOLD: begin
        if (PCSrcE) begin
          state_d = FS_REQ;
        end else if (!StallD) begin
          pcf_d   = pc_req_q + FOUR;
          state_d = FS_REQ;
        end
      end
      // A beat arriving together with a fresh redirect is the one being dropped.
      FS_DROP: if (imem_rsp_valid) state_d = FS_REQ;
      default: state_d = FS_REQ;
    endcase
    if (PCSrcE) pcf_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FS_REQ;
      pcf_q    <= RESET_PC;
      pc_req_q <= '0;
      buf_q    <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      pc_req_q <= pc_req_d;
      buf_q    <= buf_d;
    end
  end

  if_id_reg #(.DATA_WIDTH(DATA_WIDTH)) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (deliver),
    .bubble_i  (if_bubble),
    .instr_i   (deliver_instr),
    .pc_i      (pc_req_q),
    .instr_o   (instrD),
    .pc_o      (PCD),
    .pc_plus4_o(PCPlus4D),
    .valid_o   (ValidD)
  );
endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: memory model, delivery scoreboard, directed and random scenarios.
module tb_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, PCSrcE = 1'b0, StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0, ValidD;
  logic [31:0] PCTargetE = '0, imem_req_addr, imem_rsp_data = '0, instrD, PCD, PCPlus4D;

  int n_tests = 0, n_fail = 0;

  // Memory model: one outstanding request answered mem_lat cycles after acceptance.
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0, mem_lat = 1;
  logic [31:0] mem_addr = '0;
  logic [31:0] issued[$], dpc[$], dinstr[$], dp4[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  fetch #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instrD(instrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0097;  // address 0x4 holds 0x00500093
  endfunction

  // One clock: sample request side at negedge, advance memory and record deliveries after posedge.
  task automatic tick();
    logic hs, fire, sd;
    logic [31:0] a;
    @(negedge clk);
    hs = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    fire = imem_rsp_valid;
    sd = StallD;
    if (StallF) begin
      n_tests++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stallf_gate: req_valid=%b required 0", imem_req_valid);
      end
    end
    if (prev_wait && imem_req_valid) begin
      n_tests++;
      if (imem_req_addr !== prev_addr) begin
        n_fail++; $display("FAIL addr_stable: addr=%h required %h", imem_req_addr, prev_addr);
      end
    end
    prev_wait = imem_req_valid && !imem_req_ready && !PCSrcE && rst_n;
    prev_addr = a;
    @(posedge clk); #1;
    if (!rst_n) begin
      mem_pend = 1'b0;
    end else begin
      if (fire) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (hs) begin
        mem_pend = 1'b1; mem_cnt = mem_lat; mem_addr = a; issued.push_back(a);
      end
      if (!sd && ValidD === 1'b1) begin
        dpc.push_back(PCD); dinstr.push_back(instrD); dp4.push_back(PCPlus4D);
      end
    end
    imem_rsp_valid = mem_pend && (mem_cnt == 1);
    imem_rsp_data  = mem_pend ? mem_word(mem_addr) : 32'hBAD0_0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0;
    FlushD = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
    tick(); tick();
    rst_n = 1'b1;
    issued.delete(); dpc.delete(); dinstr.delete(); dp4.delete();
  endtask

  task automatic run_issued(input int n, input int bound);
    for (int i = 0; i < bound && issued.size() < n; i++) tick();
  endtask

  task automatic run_delivered(input int n, input int bound);
    for (int i = 0; i < bound && dpc.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_rsp_valid = 1'b0;
    tick();
    n_tests++;
    if ({imem_req_valid, ValidD, instrD, PCD, PCPlus4D} !== {1'b0, 1'b0, NOP_INSTR, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_state: v=%b vd=%b i=%h pc=%h p4=%h required 0 0 %h 0 0",
                         imem_req_valid, ValidD, instrD, PCD, PCPlus4D, NOP_INSTR);
    end
    rst_n = 1'b1; issued.delete(); dpc.delete(); dinstr.delete(); dp4.delete();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++; $display("FAIL first_req: v=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    tick();
    n_tests++;
    if (ValidD !== 1'b0 || instrD !== NOP_INSTR) begin
      n_fail++; $display("FAIL stale_rsp_ignored: vd=%b instr=%h required 0 %h", ValidD, instrD, NOP_INSTR);
    end
    run_delivered(1, 10);
    n_tests++;
    if (dpc.size() < 1 || dpc[0] !== RST_PC || dinstr[0] !== mem_word(RST_PC)) begin
      n_fail++; $display("FAIL first_delivery: count=%0d required pc %h instr %h", dpc.size(), RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick(); tick();
    n_tests++;
    if (dpc.size() != 1) begin
      n_fail++; $display("FAIL latency: deliveries after 2 cycles=%0d required 1", dpc.size());
    end
    run_delivered(3, 30);
    n_tests++;
    if (dpc.size() < 3 || issued.size() < 3) begin
      n_fail++; $display("FAIL stream_timeout: delivered=%0d issued=%0d required 3", dpc.size(), issued.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (issued[i] !== 32'(4*i) || dpc[i] !== 32'(4*i) || dp4[i] !== 32'(4*i+4) || dinstr[i] !== mem_word(32'(4*i))) begin
          n_fail++; $display("FAIL stream[%0d]: addr=%h pc=%h p4=%h instr=%h required pc %h", i, issued[i], dpc[i], dp4[i], dinstr[i], 4*i);
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [96:0] snap;
    do_reset();
    run_issued(2, 20);
    n_tests++;
    if (issued.size() != 2 || issued[1] !== 32'h4) begin
      n_fail++; $display("FAIL hold_setup: issued=%0d required 2 ending at 4", issued.size());
    end
    StallD = 1'b1;
    snap = {ValidD, instrD, PCD, PCPlus4D};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({ValidD, instrD, PCD, PCPlus4D} !== snap) begin
        n_fail++; $display("FAIL hold_stable[%0d]: instr=%h pc=%h required unchanged", i, instrD, PCD);
      end
    end
    n_tests++;
    if (issued.size() != 2) begin
      n_fail++; $display("FAIL hold_no_req: issued=%0d required 2", issued.size());
    end
    StallD = 1'b0;
    tick();
    n_tests++;
    if (instrD !== 32'h0050_0093 || PCD !== 32'h4 || PCPlus4D !== 32'h8 || ValidD !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: instr=%h pc=%h p4=%h vd=%b required 00500093 4 8 1", instrD, PCD, PCPlus4D, ValidD);
    end
    run_issued(3, 10);
    n_tests++;
    if (issued.size() < 3 || issued[2] !== 32'h8) begin
      n_fail++; $display("FAIL hold_next_addr: issued=%0d required addr 8", issued.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    tick();
    PCSrcE = 1'b0;
    n_tests++;
    if (ValidD !== 1'b0 || instrD !== NOP_INSTR) begin
      n_fail++; $display("FAIL redirect_bubble: vd=%b instr=%h required 0 %h", ValidD, instrD, NOP_INSTR);
    end
    run_delivered(1, 20);
    n_tests++;
    if (issued.size() < 2 || issued[1] !== 32'h100 || dpc.size() < 1 || dpc[0] !== 32'h100 || dinstr[0] !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL redirect_target: issued=%0d delivered=%0d required addr/pc 100", issued.size(), dpc.size());
    end
    // Redirect before the response arrives: the late beat must be dropped.
    do_reset();
    mem_lat = 3;
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0; mem_lat = 1;
    run_delivered(1, 20);
    n_tests++;
    if (issued.size() != 2 || issued[1] !== 32'h200 || dpc.size() != 1 || dpc[0] !== 32'h200 || dinstr[0] !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL drop_late_rsp: issued=%0d delivered=%0d required 2 1 at pc 200", issued.size(), dpc.size());
    end
  endtask

  task automatic test_ready_stallf();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      StallF = (i == 1); #1;
      n_tests++;
      if (StallF ? (imem_req_valid !== 1'b0) : (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)) begin
        n_fail++; $display("FAIL backpressure[%0d]: v=%b addr=%h stallf=%b", i, imem_req_valid, imem_req_addr, StallF);
      end
      tick();
    end
    n_tests++;
    if (issued.size() != 0) begin
      n_fail++; $display("FAIL no_issue_unready: issued=%0d required 0", issued.size());
    end
    StallF = 1'b0; imem_req_ready = 1'b1;
    run_delivered(2, 20);
    n_tests++;
    if (issued.size() < 2 || issued[0] !== 32'h0 || issued[1] !== 32'h4 || dpc.size() < 2 || dpc[1] !== 32'h4) begin
      n_fail++; $display("FAIL no_duplicate: issued=%0d delivered=%0d required 0,4", issued.size(), dpc.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    tick();
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    n_tests++;
    if (instrD !== 32'h0000_0013 || ValidD !== 1'b0) begin
      n_fail++; $display("FAIL flush_bubble: instr=%h vd=%b required 00000013 0", instrD, ValidD);
    end
    run_issued(2, 10);
    n_tests++;
    if (issued.size() < 2 || issued[1] !== 32'h4 || dpc.size() != 0) begin
      n_fail++; $display("FAIL flush_pc_advance: issued=%0d delivered=%0d required next addr 4, none delivered", issued.size(), dpc.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    tick();
    PCSrcE = 1'b0;
    run_delivered(1, 20);
    run_issued(3, 10);
    n_tests++;
    if (dpc.size() < 1 || dpc[0] !== 32'hFFFF_FFFC || dp4[0] !== 32'h0 || dinstr[0] !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL pc_wrap: delivered=%0d required pc fffffffc p4 0", dpc.size());
    end
    n_tests++;
    if (issued.size() < 3 || issued[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next_addr: issued=%0d required addr 0 after fffffffc", issued.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_issued(2, 20);
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({imem_req_valid, ValidD, instrD, PCD, PCPlus4D} !== {1'b0, 1'b0, NOP_INSTR, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid: v=%b vd=%b i=%h pc=%h p4=%h required reset values",
                         imem_req_valid, ValidD, instrD, PCD, PCPlus4D);
    end
    rst_n = 1'b1; issued.delete(); dpc.delete(); dinstr.delete(); dp4.delete();
    run_delivered(1, 10);
    n_tests++;
    if (issued.size() < 1 || issued[0] !== RST_PC || dpc.size() < 1 || dpc[0] !== RST_PC) begin
      n_fail++; $display("FAIL reset_mid_restart: issued=%0d delivered=%0d required from %h", issued.size(), dpc.size(), RST_PC);
    end
  endtask

  // Random stalls, backpressure and latency; the program must still stream sequentially.
  task automatic test_random();
    logic [96:0] snap;
    logic sd;
    int target;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      StallD = ($urandom_range(0, 9) < 3);
      StallF = ($urandom_range(0, 9) < 2);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      mem_lat = $urandom_range(1, 3);
      snap = {ValidD, instrD, PCD, PCPlus4D};
      sd = StallD;
      tick();
      n_tests++;
      if (sd ? ({ValidD, instrD, PCD, PCPlus4D} !== snap) : (ValidD === 1'b0 && instrD !== NOP_INSTR)) begin
        n_fail++; $display("FAIL rand_ifid[%0d]: stalld=%b vd=%b instr=%h pc=%h", c, sd, ValidD, instrD, PCD);
      end
    end
    StallD = 1'b0; StallF = 1'b0; imem_req_ready = 1'b1;
    target = issued.size();
    run_delivered(target, 40);
    n_tests++;
    if (dpc.size() < target || target < 20) begin
      n_fail++; $display("FAIL rand_drain: delivered=%0d issued=%0d required >= 20 and equal", dpc.size(), target);
    end
    for (int i = 0; i < dpc.size() && i < issued.size(); i++) begin
      n_tests++;
      if (issued[i] !== RST_PC + 32'(4*i) || dpc[i] !== RST_PC + 32'(4*i) ||
          dp4[i] !== dpc[i] + 32'd4 || dinstr[i] !== mem_word(RST_PC + 32'(4*i))) begin
        n_fail++; $display("FAIL rand_seq[%0d]: addr=%h pc=%h p4=%h instr=%h required pc %h",
                           i, issued[i], dpc[i], dp4[i], dinstr[i], RST_PC + 32'(4*i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect();
    test_ready_stallf();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction and address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have port PCSrcE, input, 1 bit: redirect request from execute.
REQ-006 The block SHALL have port PCTargetE, input, DATA_WIDTH: redirect target.
REQ-007 The block SHALL have ports StallF and StallD, inputs, 1 bit each: hazard-unit stalls.
REQ-008 The block SHALL have port FlushD, input, 1 bit: bubble insertion into the IF/ID register.
REQ-009 The block SHALL have ports imem_req_valid (output, 1 bit), imem_req_addr (output, DATA_WIDTH) and imem_req_ready (input, 1 bit): the instruction-memory request channel.
REQ-010 The block SHALL have ports imem_rsp_valid (input, 1 bit) and imem_rsp_data (input, DATA_WIDTH): the instruction-memory response channel.
REQ-011 The block SHALL have outputs instrD, PCD and PCPlus4D (DATA_WIDTH each) and ValidD (1 bit): the IF/ID register contents fed to decode.

Function
REQ-012 The block SHALL hold PCF and a 4-state FSM: REQ, WAIT, DROP, HOLD.
REQ-013 REQ: the block SHALL drive imem_req_valid=!StallF and imem_req_addr=PCF; on valid&&ready it SHALL latch PCReq<=PCF and go to WAIT; the request address is held stable while valid is high and ready is low.
REQ-014 At most one request SHALL be outstanding; imem_req_valid SHALL be 0 in WAIT, DROP and HOLD.
REQ-015 In WAIT, on imem_rsp_valid with StallD=0, the block SHALL load instrD<=imem_rsp_data, PCD<=PCReq, PCPlus4D<=PCReq+4 and ValidD<=1, set PCF<=PCReq+4, and go to REQ.
REQ-016 In WAIT, on imem_rsp_valid with StallD=1, the block SHALL capture the data in a one-entry buffer, go to HOLD, and leave the IF/ID register unchanged.
REQ-017 In HOLD, once StallD=0, the block SHALL transfer the buffer into IF/ID as in REQ-015 and go to REQ.
REQ-018 Whenever StallD=0 and no instruction is delivered that cycle, the block SHALL load IF/ID with a bubble: instrD=NOP (32'h0000_0013), ValidD=0, PCD and PCPlus4D unchanged.
REQ-019 While StallD=1 (and no flush or redirect), the IF/ID register SHALL hold its value.
REQ-020 FlushD=1 SHALL load a bubble regardless of StallD and SHALL discard any instruction delivered that cycle.
REQ-021 PCSrcE=1 SHALL take priority over StallF, StallD and FlushD, with these effects:
- PCF<=PCTargetE with bits [1:0] forced to 0.
- IF/ID SHALL load a bubble.
- In WAIT, or in REQ with a handshake completing that cycle, the next state SHALL be DROP; in HOLD, the buffer SHALL be discarded and the next state SHALL be REQ; otherwise the next state SHALL be REQ.
- A response arriving in the same cycle as PCSrcE in WAIT SHALL be discarded, and the next state SHALL be REQ.
REQ-022 DROP SHALL discard the next imem_rsp_valid beat and then go to REQ; a further PCSrcE in DROP SHALL update PCF and stay in DROP.
REQ-023 PC arithmetic SHALL be modulo 2^DATA_WIDTH; PCReq=32'hFFFF_FFFC SHALL yield PCPlus4D=0.
REQ-024 Latency: with request accepted in cycle N and response in N+1, instrD SHALL be valid from the edge ending N+1; throughput SHALL be one instruction per two cycles minimum.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set PCF=RESET_PC, FSM=REQ, buffer empty, instrD=NOP, PCD=0, PCPlus4D=0, ValidD=0.
REQ-026 imem_req_valid SHALL be 0 during any cycle with rst_n=0.
REQ-027 A response arriving in the first cycle after reset SHALL be ignored.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request without DROP tracking; the memory side is reset by the same rst_n.

Structure
REQ-029 The constants NOP_INSTR and RESET_PC default and the enum fetch_state_t SHALL reside in the shared package riscv_pkg.
REQ-030 The IF/ID register (enable and bubble/flush load) SHALL be a single sub-module if_id_reg; the FSM, PCF and the buffer SHALL stay in fetch.

Verification
REQ-031 Release reset, ready=1, 1-cycle memory -> addresses 0x0,0x4,0x8 issued; ValidD pulses with PCD 0x0,0x4,0x8; PCPlus4D=PCD+4.
REQ-032 StallD=1 across response for PC 0x4 data 0x00500093 -> HOLD; instrD unchanged; on StallD=0 instrD=0x00500093, PCD=0x4.
REQ-033 PCSrcE=1, PCTargetE=0x103 while WAIT -> ValidD=0 bubble; old response discarded; next request addr=0x100.
REQ-034 imem_req_ready=0 for 3 cycles with StallF toggling -> addr stable while valid high; no request issued while StallF=1; no duplicate fetch.
REQ-035 FlushD=1 coincident with a delivered response -> instrD=0x00000013, ValidD=0; PCF still advances.
REQ-036 rst_n=0 asserted in WAIT -> all outputs at reset values next cycle; first post-reset request addr=RESET_PC.
